// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: load-size codes, writeback-stage control struct, register-zero address.
package mips_pkg;

    localparam logic [1:0] LS_BYTE    = 2'b00;
    localparam logic [1:0] LS_HALF    = 2'b01;
    localparam logic [1:0] LS_WORD    = 2'b10;
    localparam logic [1:0] LS_ILLEGAL = 2'b11;

    localparam int REG_ZERO = 0;

    // Width-independent part of the MEM/WB stage register; the datapath fields
    // live beside it because their widths are module parameters.
    typedef struct packed {
        logic       valid;
        logic       r_en;
        logic       wb_en;
        logic [1:0] lsize;
        logic       lunsigned;
    } stage_ctrl_t;

endpackage

// File: rtl/load_align.sv
// Little-endian byte/halfword/word lane extraction with sign or zero extension.
// Purely combinational; flags misaligned offsets and the illegal size code.
module load_align
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] read_data,
    input  logic [1:0]        offset,
    input  logic [1:0]        lsize,
    input  logic              lunsigned,
    output logic [DATA_W-1:0] ext_data,
    output logic              misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = read_data[7:0];
            2'd1:    byte_sel = read_data[15:8];
            2'd2:    byte_sel = read_data[23:16];
            default: byte_sel = read_data[31:24];
        endcase
        half_sel = offset[1] ? read_data[31:16] : read_data[15:0];
    end

    always_comb begin
        ext_data = read_data;
        misalign = 1'b0;
        case (lsize)
            LS_BYTE: ext_data = {{(DATA_W-8){~lunsigned & byte_sel[7]}}, byte_sel};
            LS_HALF: begin
                ext_data = {{(DATA_W-16){~lunsigned & half_sel[15]}}, half_sel};
                misalign = offset[0];
            end
            LS_WORD: misalign = (offset != 2'd0);
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus writeback: load extraction, writeback mux, forwarding info, retire count.
// Outputs depend only on the stage register; flush beats stall beats load.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0]     mem_alu_res,
    input  logic [DATA_W-1:0]     mem_read_data,
    input  logic                  mem_r_en,
    input  logic                  mem_wb_en,
    input  logic [1:0]            mem_lsize,
    input  logic                  mem_lunsigned,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_dest,
    output logic [DATA_W-1:0]     wb_value,
    output logic                  fwd_valid,
    output logic                  misalign,
    output logic [CNT_W-1:0]      retired
);

    stage_ctrl_t           ctrl_q, ctrl_d;
    logic [REG_ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0]     alu_q, alu_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [CNT_W-1:0]      retired_q, retired_d;

    logic [DATA_W-1:0] ext_data;
    logic              align_err;
    logic              retire;

    always_comb begin
        ctrl_d  = ctrl_q;
        dest_d  = dest_q;
        alu_d   = alu_q;
        rdata_d = rdata_q;
        if (flush) begin
            ctrl_d.valid = 1'b0;
        end else if (!stall) begin
            ctrl_d.valid     = mem_valid;
            ctrl_d.r_en      = mem_r_en;
            ctrl_d.wb_en     = mem_wb_en;
            ctrl_d.lsize     = mem_lsize;
            ctrl_d.lunsigned = mem_lunsigned;
            dest_d           = mem_dest;
            alu_d            = mem_alu_res;
            rdata_d          = mem_read_data;
        end
    end

    // An instruction retires on the edge it leaves the stage, misaligned or not.
    assign retire    = ctrl_q.valid & ~stall & ~flush;
    assign retired_d = retired_q + (retire ? CNT_W'(1) : CNT_W'(0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            dest_q    <= '0;
            alu_q     <= '0;
            rdata_q   <= '0;
            retired_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            dest_q    <= dest_d;
            alu_q     <= alu_d;
            rdata_q   <= rdata_d;
            retired_q <= retired_d;
        end
    end

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .read_data (rdata_q),
        .offset    (alu_q[1:0]),
        .lsize     (ctrl_q.lsize),
        .lunsigned (ctrl_q.lunsigned),
        .ext_data  (ext_data),
        .misalign  (align_err)
    );

    assign misalign  = ctrl_q.valid & ctrl_q.r_en & align_err;
    assign wb_value  = ctrl_q.r_en ? ext_data : alu_q;
    assign wb_dest   = dest_q;
    assign wb_we     = ctrl_q.valid & ctrl_q.wb_en &
                       (dest_q != REG_ADDR_W'(REG_ZERO)) & ~misalign;
    assign fwd_valid = wb_we;
    assign retired   = retired_q;

endmodule
